// File: rtl/ext_bus_pkg.sv
// rtl/ext_bus_pkg.sv - shared types and sizing helpers for the external-bus sequencer
//
// Purpose: state encoding and width helpers shared by ext_bus_sequencer and
//          bus_wait_timer.
// Contents:
//   bus_state_e  2-bit sequencer state (IDLE / ADDR / DATA / RESP)
//   beats()      number of pad-width slices in a bus word
//   idx_w()      width of an index that counts 0..n-1 (minimum 1)
//   cnt_w()      width of a counter that reaches n (saturating counters)
package ext_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } bus_state_e;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_PIN_W   = 8;
    localparam int DEF_TIMEOUT = 15;

    function automatic int beats(input int w, input int pin_w);
        return w / pin_w;
    endfunction

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ext_bus_sequencer_wait_timer.sv
// rtl/ext_bus_sequencer_wait_timer.sv - saturating RDY-low wait counter with expiry flag
//
// Purpose: counts consecutive wait cycles of one data beat.
// Ports:
//   clk_cpu  in   clock
//   rst_n    in   synchronous active-low reset
//   clear    in   return the count to zero (has priority over inc)
//   inc      in   count one more wait cycle (saturates at TIMEOUT)
//   expired  out  the count has reached TIMEOUT-1: one more wait cycle aborts
module bus_wait_timer
    import ext_bus_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk_cpu,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CNT_W = cnt_w(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_W'(TIMEOUT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_cpu) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The sequencer decides on the edge where the count would step past
    // TIMEOUT-1, so the flag marks the last tolerated value, not TIMEOUT.
    assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ext_bus_sequencer.sv
// rtl/ext_bus_sequencer.sv - serialises one CPU request into address and data beats on the pads
//
// Purpose: accepts one CPU memory request, drives the address slice by slice
//          on addr_pins, then moves data slice by slice on the bidirectional
//          pins with RDY wait states and a per-beat timeout.
// Ports:
//   clk_cpu, rst_n                     clock, synchronous active-low reset
//   req_valid/req_ready                request handshake (ready only in IDLE)
//   req_we, req_addr, req_wdata        request payload
//   resp_valid, resp_err, resp_rdata   one-cycle completion, error flag, read word
//   rdy_in                             external ready, low inserts wait states
//   addr_pins, addr_strobe, addr_last  address beat outputs
//   data_in, data_out, data_oe         bidirectional pad group
//   busy                               not IDLE
// All outputs decode from registered state only.
module ext_bus_sequencer
    import ext_bus_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int PIN_W   = DEF_PIN_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk_cpu,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    input  logic              rdy_in,
    output logic [PIN_W-1:0]  addr_pins,
    output logic              addr_strobe,
    output logic              addr_last,
    input  logic [PIN_W-1:0]  data_in,
    output logic [PIN_W-1:0]  data_out,
    output logic [PIN_W-1:0]  data_oe,
    output logic              busy
);

    localparam int AB     = beats(ADDR_W, PIN_W);
    localparam int DB     = beats(DATA_W, PIN_W);
    localparam int BEAT_W = idx_w((AB > DB) ? AB : DB);

    bus_state_e        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              err_q, err_d;

    logic              wait_clear;
    logic              wait_inc;
    logic              wait_expired;

    // Any cycle outside DATA, or any ready data beat, restarts the wait
    // budget, so each beat enters DATA with a fresh count.
    assign wait_clear = (state_q != ST_DATA) || rdy_in;
    assign wait_inc   = (state_q == ST_DATA) && !rdy_in;

    bus_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk_cpu (clk_cpu),
        .rst_n   (rst_n),
        .clear   (wait_clear),
        .inc     (wait_inc),
        .expired (wait_expired)
    );

    // State and datapath registers.
    always_ff @(posedge clk_cpu) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            resp_rdata_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            resp_rdata_q <= resp_rdata_d;
            err_q        <= err_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        resp_rdata_d = resp_rdata_q;
        err_d        = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    beat_d  = '0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (beat_q == BEAT_W'(AB - 1)) begin
                    beat_d  = '0;
                    state_d = ST_DATA;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (rdy_in) begin
                    if (!we_q) begin
                        for (int k = 0; k < DB; k++) begin
                            if (beat_q == BEAT_W'(k)) begin
                                rdata_d[k*PIN_W +: PIN_W] = data_in;
                            end
                        end
                    end
                    if (beat_q == BEAT_W'(DB - 1)) begin
                        // rdata_d already holds the final slice captured this edge.
                        resp_rdata_d = we_q ? '0 : rdata_d;
                        err_d        = 1'b0;
                        state_d      = ST_RESP;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end else if (wait_expired) begin
                    resp_rdata_d = '0;
                    err_d        = 1'b1;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                beat_d  = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore output decode.
    always_comb begin
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_err    = 1'b0;
        addr_pins   = '0;
        addr_strobe = 1'b0;
        addr_last   = 1'b0;
        data_out    = '0;
        data_oe     = '0;
        busy        = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_ADDR: begin
                addr_strobe = 1'b1;
                addr_last   = (beat_q == BEAT_W'(AB - 1));
                for (int k = 0; k < AB; k++) begin
                    if (beat_q == BEAT_W'(k)) begin
                        addr_pins = addr_q[k*PIN_W +: PIN_W];
                    end
                end
            end
            ST_DATA: begin
                if (we_q) begin
                    data_oe = '1;
                    for (int k = 0; k < DB; k++) begin
                        if (beat_q == BEAT_W'(k)) begin
                            data_out = wdata_q[k*PIN_W +: PIN_W];
                        end
                    end
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    assign resp_rdata = resp_rdata_q;

endmodule
